// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// per-stage datapath enables, run/step/halt debug control, a PC breakpoint
// and a wrapping retired-instruction counter.
module instr_sequencer #(
   parameter int MEM_LAT   = 1,   // cycles spent in MEM (1..15)
   parameter int CNT_WIDTH = 16   // retired-instruction counter width
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RUN,
   input  logic                 STEP,
   input  logic                 RESUME,
   input  logic                 HALT_REQ,
   input  logic                 BRK_EN,
   input  logic [7:0]           BRK_ADDR,
   input  logic [7:0]           PC,
   input  logic [1:0]           OPCODE,
   output logic                 IR_LOAD,
   output logic                 PC_EN,
   output logic                 REG_WE_EN,
   output logic                 MEM_RD_EN,
   output logic                 MEM_WE_EN,
   output logic                 INSTR_DONE,
   output logic                 BUSY,
   output logic                 HALTED,
   output logic [2:0]           STATE,
   output logic [CNT_WIDTH-1:0] INSTR_CNT
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

   state_t               state_reg, state_next;
   logic [1:0]           op_reg, op_next;
   logic                 step_reg, step_next;
   logic                 halt_reg, halt_next;
   logic                 brk_skip_reg, brk_skip_next;
   logic [3:0]           mem_cnt_reg, mem_cnt_next;
   logic [CNT_WIDTH-1:0] instr_cnt_reg;

   logic busy;
   logic brk_hit;
   logic is_mem_op;

   assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                      (state_reg == S_EXEC)  || (state_reg == S_MEM)    ||
                      (state_reg == S_WB);
   // brk_skip lets the instruction sitting on the breakpoint run once after
   // leaving HALT instead of re-trapping immediately.
   assign brk_hit   = BRK_EN && (PC == BRK_ADDR) && !brk_skip_reg;
   assign is_mem_op = (op_reg == OP_LOAD) || (op_reg == OP_STORE);

   // State and control-flag registers; reset aborts any instruction in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= S_IDLE;
         op_reg       <= 2'b00;
         step_reg     <= 1'b0;
         halt_reg     <= 1'b0;
         brk_skip_reg <= 1'b0;
         mem_cnt_reg  <= 4'd0;
      end else begin
         state_reg    <= state_next;
         op_reg       <= op_next;
         step_reg     <= step_next;
         halt_reg     <= halt_next;
         brk_skip_reg <= brk_skip_next;
         mem_cnt_reg  <= mem_cnt_next;
      end
   end

   // Retired-instruction counter, bumped on the WB edge and wrapping freely.
   always_ff @(posedge CLK) begin
      if (RST) begin
         instr_cnt_reg <= '0;
      end else if (state_reg == S_WB) begin
         instr_cnt_reg <= instr_cnt_reg + CNT_WIDTH'(1);
      end
   end

   // Next-state logic and debug-flag bookkeeping.
   always_comb begin
      state_next    = state_reg;
      op_next       = op_reg;
      step_next     = step_reg;
      brk_skip_next = brk_skip_reg;
      mem_cnt_next  = mem_cnt_reg;
      // A halt request during an instruction is remembered until the
      // instruction boundary; it never cuts the instruction short.
      halt_next     = halt_reg | (busy & HALT_REQ);

      case (state_reg)
         S_IDLE: begin
            if (HALT_REQ) begin
               state_next = S_HALT;
            end else if (STEP) begin
               state_next = S_FETCH;
               step_next  = 1'b1;
            end else if (RUN) begin
               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (brk_hit) begin
               state_next = S_HALT;
               step_next  = 1'b0;
               halt_next  = 1'b0;
            end else begin
               state_next    = S_DECODE;
               op_next       = OPCODE;
               brk_skip_next = 1'b0;
            end
         end
         S_DECODE: begin
            state_next = S_EXEC;
         end
         S_EXEC: begin
            if (is_mem_op) begin
               state_next   = S_MEM;
               mem_cnt_next = MEM_LOAD;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            if (mem_cnt_reg == 4'd0) begin
               state_next = S_WB;
            end else begin
               mem_cnt_next = mem_cnt_reg - 4'd1;
            end
         end
         S_WB: begin
            // A request arriving in WB itself is honoured at this boundary too.
            if (halt_reg || HALT_REQ) begin
               state_next = S_HALT;
               halt_next  = 1'b0;
               step_next  = 1'b0;
            end else if (step_reg) begin
               state_next = S_IDLE;
               step_next  = 1'b0;
            end else if (RUN) begin
               state_next = S_FETCH;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_HALT: begin
            if (HALT_REQ) begin
               state_next = S_HALT;
            end else if (STEP) begin
               state_next    = S_FETCH;
               step_next     = 1'b1;
               brk_skip_next = 1'b1;
            end else if (RESUME && RUN) begin
               state_next    = S_FETCH;
               brk_skip_next = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Stage enables and status flags decoded from registered state and op.
   always_comb begin
      IR_LOAD    = 1'b0;
      PC_EN      = 1'b0;
      REG_WE_EN  = 1'b0;
      MEM_RD_EN  = 1'b0;
      MEM_WE_EN  = 1'b0;
      INSTR_DONE = 1'b0;
      case (state_reg)
         S_FETCH: IR_LOAD = !brk_hit;
         S_MEM: begin
            MEM_RD_EN = (op_reg == OP_LOAD);
            // Single write strobe on the last MEM cycle.
            MEM_WE_EN = (op_reg == OP_STORE) && (mem_cnt_reg == 4'd0);
         end
         S_WB: begin
            PC_EN      = 1'b1;
            REG_WE_EN  = (op_reg == OP_ADD) || (op_reg == OP_LOAD);
            INSTR_DONE = 1'b1;
         end
         default: ;
      endcase
   end

   assign BUSY      = busy;
   assign HALTED    = (state_reg == S_HALT);
   assign STATE     = state_reg;
   assign INSTR_CNT = instr_cnt_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes one expected record
// per instruction it launches; a negedge monitor pops and compares on every
// INSTR_DONE. Directed checks cover reset, breakpoint, halt and step control.
module tb_instr_sequencer;

   localparam int MEM_LAT   = 3;
   localparam int CNT_WIDTH = 4;

   logic                 clk = 1'b0;
   logic                 rst, run, step, resume, halt_req, brk_en;
   logic [7:0]           brk_addr, pc;
   logic [1:0]           opcode;
   logic                 ir_load, pc_en, reg_we_en, mem_rd_en, mem_we_en;
   logic                 instr_done, busy, halted;
   logic [2:0]           state;
   logic [CNT_WIDTH-1:0] instr_cnt;

   instr_sequencer #(.MEM_LAT(MEM_LAT), .CNT_WIDTH(CNT_WIDTH)) dut (
      .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .RESUME(resume),
      .HALT_REQ(halt_req), .BRK_EN(brk_en), .BRK_ADDR(brk_addr), .PC(pc),
      .OPCODE(opcode), .IR_LOAD(ir_load), .PC_EN(pc_en),
      .REG_WE_EN(reg_we_en), .MEM_RD_EN(mem_rd_en), .MEM_WE_EN(mem_we_en),
      .INSTR_DONE(instr_done), .BUSY(busy), .HALTED(halted), .STATE(state),
      .INSTR_CNT(instr_cnt)
   );

   always #5 clk = ~clk;

   // Simple program counter: steps by one whenever the sequencer enables it.
   always @(posedge clk) begin
      if (rst) pc <= 8'd0;
      else if (pc_en) pc <= pc + 8'd1;
   end

   typedef struct {
      logic [1:0] op;
      int lat;      // FETCH..WB inclusive
      int rd;       // MEM_RD_EN cycles
      int we;       // MEM_WE_EN cycles
      int we_pos;   // MEM cycle index carrying the write strobe
      int reg_we;
      int cnt;      // INSTR_CNT value seen during WB (before increment)
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_cnt  = 0;
   int   done_seen = 0;
   int   we_total  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push(input logic [1:0] op);
      exp_t e;
      e.op     = op;
      e.lat    = (op == 2'b01 || op == 2'b10) ? 4 + MEM_LAT : 4;
      e.rd     = (op == 2'b01) ? MEM_LAT : 0;
      e.we     = (op == 2'b10) ? 1 : 0;
      e.we_pos = (op == 2'b10) ? MEM_LAT : 0;
      e.reg_we = (op == 2'b00 || op == 2'b01) ? 1 : 0;
      e.cnt    = exp_cnt % (1 << CNT_WIDTH);
      exp_cnt++;
      exp_q.push_back(e);
   endtask

   // Monitor: tracks the instruction in flight and scores it on INSTR_DONE.
   int m_cyc = 0, m_rd = 0, m_we = 0, m_we_pos = 0, m_mem_idx = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (state == 3'd1 && ir_load) begin
            m_cyc = 1; m_rd = 0; m_we = 0; m_we_pos = 0; m_mem_idx = 0;
         end else if (busy) begin
            m_cyc++;
         end
         if (state == 3'd4) m_mem_idx++;
         if (mem_rd_en) m_rd++;
         if (mem_we_en) begin
            m_we++; m_we_pos = m_mem_idx; we_total++;
         end
         if (instr_done) begin
            done_seen++;
            chk("done_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               $display("retire op=%0d lat=%0d rd=%0d we=%0d cnt=%0d", e.op, m_cyc, m_rd, m_we, instr_cnt);
               chk("latency", m_cyc, e.lat);
               chk("mem_rd_cycles", m_rd, e.rd);
               chk("mem_we_cycles", m_we, e.we);
               chk("mem_we_position", m_we_pos, e.we_pos);
               chk("reg_we_en", int'(reg_we_en), e.reg_we);
               chk("pc_en", int'(pc_en), 1);
               chk("instr_cnt", int'(instr_cnt), e.cnt);
            end
         end
      end
   end

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int n, input int budget);
      int target;
      int c;
      target = done_seen + n;
      c = 0;
      while (done_seen < target && c < budget) begin
         sample();
         c++;
      end
      if (done_seen < target) chk("done_timeout", done_seen, target);
   endtask

   task automatic wait_state(input int s, input int budget);
      int c;
      c = 0;
      sample();
      while (int'(state) != s && c < budget) begin
         sample();
         c++;
      end
      if (int'(state) != s) chk("state_timeout", int'(state), s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_cnt = 0;
      sample();
   endtask

   initial begin
      int we_before;
      rst = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0; halt_req = 1'b0;
      brk_en = 1'b0; brk_addr = 8'h00; opcode = 2'b00;
      do_reset();

      // Reset state
      chk("rst_state", int'(state), 0);
      chk("rst_enables", int'({ir_load, pc_en, reg_we_en, mem_rd_en, mem_we_en}), 0);
      chk("rst_flags", int'({instr_done, busy, halted}), 0);
      chk("rst_cnt", int'(instr_cnt), 0);

      // Free-run adds, long enough to wrap the 4-bit counter
      opcode = 2'b00; run = 1'b1;
      for (int i = 0; i < 18; i++) push(2'b00);
      repeat (13) @(posedge clk);
      #1;
      chk("add_cnt_after_12", int'(instr_cnt), 3);
      chk("add_state_fetch", int'(state), 1);
      wait_done(18 - 3, 200);
      run = 1'b0;
      sample();
      chk("add_idle_after", int'(state), 0);
      chk("add_cnt_wrapped", int'(instr_cnt), 2);

      // Free-run stores with a 3-cycle MEM stage
      opcode = 2'b10; run = 1'b1;
      push(2'b10); push(2'b10);
      wait_done(2, 100);
      run = 1'b0;
      sample();
      chk("store_idle_after", int'(state), 0);

      // Single step of a load, then nothing further
      opcode = 2'b01;
      push(2'b01);
      step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      wait_done(1, 50);
      repeat (4) sample();
      chk("step_idle", int'(state), 0);
      chk("step_not_busy", int'(busy), 0);
      chk("step_cnt", int'(instr_cnt), exp_cnt % (1 << CNT_WIDTH));

      // Breakpoint at PC 05, then resume past it
      do_reset();
      opcode = 2'b00; brk_en = 1'b1; brk_addr = 8'h05; run = 1'b1;
      for (int i = 0; i < 5; i++) push(2'b00);
      wait_done(5, 100);
      sample();
      chk("brk_fetch_state", int'(state), 1);
      chk("brk_ir_load", int'(ir_load), 0);
      sample();
      chk("brk_halt_state", int'(state), 6);
      chk("brk_halted", int'(halted), 1);
      chk("brk_not_busy", int'(busy), 0);
      run = 1'b0; resume = 1'b1;
      @(posedge clk); #1 resume = 1'b0;
      sample(); sample();
      chk("resume_norun_ignored", int'(state), 6);
      run = 1'b1; resume = 1'b1;
      for (int i = 0; i < 3; i++) push(2'b00);
      @(posedge clk); #1 resume = 1'b0;
      wait_done(3, 100);
      run = 1'b0; brk_en = 1'b0;
      sample();
      chk("brk_run_idle", int'(state), 0);
      chk("brk_pc", int'(pc), 8);

      // Halt request during DECODE, then step+resume together
      opcode = 2'b00; run = 1'b1;
      push(2'b00);
      wait_state(2, 20);
      halt_req = 1'b1;
      @(posedge clk); #1 halt_req = 1'b0;
      wait_done(1, 20);
      sample();
      chk("hreq_halt_state", int'(state), 6);
      chk("hreq_halted", int'(halted), 1);
      halt_req = 1'b1; step = 1'b1;
      @(posedge clk); #1 step = 1'b0; halt_req = 1'b0;
      sample();
      chk("hreq_blocks_exit", int'(state), 6);
      push(2'b00);
      step = 1'b1; resume = 1'b1;
      @(posedge clk); #1 step = 1'b0; resume = 1'b0;
      wait_done(1, 20);
      sample();
      chk("step_wins_idle", int'(state), 0);
      run = 1'b0;
      sample();
      chk("step_wins_stays", int'(state), 0);

      // Reset in the first MEM cycle of a store
      we_before = we_total;
      opcode = 2'b10; run = 1'b1;
      wait_state(4, 20);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; run = 1'b0;
      exp_cnt = 0;
      sample();
      chk("mrst_state", int'(state), 0);
      chk("mrst_cnt", int'(instr_cnt), 0);
      chk("mrst_not_busy", int'(busy), 0);
      repeat (6) sample();
      chk("mrst_no_write", we_total, we_before);
      chk("mrst_stays_idle", int'(state), 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global guard so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

endmodule
